// File: rtl/complex_nr_mult_stim_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : complex_nr_mult_stim_gen_if                                   |
// | Purpose  : Operand/result handshake bundle between the stimulus          |
// |            generator and the complex multiplier under test.              |
// | Signals  : op_val/op_ready   - operand handshake                         |
// |            res_val/res_ready - result handshake                          |
// |            op_1_re..op_2_im  - operand buses, DATA_WIDTH bits each       |
// |            sw_rst            - one-cycle abort pulse to the multiplier   |
// | Modports : master (stimulus generator side), slave (multiplier side)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface complex_nr_mult_stim_gen_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  op_val;
   logic                  op_ready;
   logic                  res_val;
   logic                  res_ready;
   logic                  sw_rst;
   logic [DATA_WIDTH-1:0] op_1_re;
   logic [DATA_WIDTH-1:0] op_1_im;
   logic [DATA_WIDTH-1:0] op_2_re;
   logic [DATA_WIDTH-1:0] op_2_im;

   modport master (
      output op_val, res_ready, sw_rst, op_1_re, op_1_im, op_2_re, op_2_im,
      input  op_ready, res_val
   );

   modport slave (
      input  op_val, res_ready, sw_rst, op_1_re, op_1_im, op_2_re, op_2_im,
      output op_ready, res_val
   );
endinterface
`default_nettype wire

// File: rtl/complex_nr_mult_stim_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : complex_nr_mult_stim_gen                                      |
// | Purpose  : Stimulus generator for a complex multiplier. Per run it       |
// |            issues trans_num transactions: load four operands (fixed,     |
// |            LFSR random, corner or ramp pattern), optional idle gap,      |
// |            operand handshake, then result handshake. A transaction       |
// |            stuck in SEND or WAIT_RES for RES_TIMEOUT cycles aborts the   |
// |            run with a sticky err flag and a one-cycle sw_rst pulse.      |
// | Ports    : clk, rstn (async, active low)                                 |
// |            start, mode[1:0], trans_num[15:0] - run control (IDLE only)   |
// |            mul (master modport)              - multiplier handshakes     |
// |            busy, done, err, trans_cnt[15:0]  - run status                |
// | Options  : COMPLEX_STIM_RES_THROTTLE_EN - when defined, res_ready        |
// |            alternates 0,1,0,... in WAIT_RES instead of staying high.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module complex_nr_mult_stim_gen #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned GAP_CYCLES  = 2,
   parameter int unsigned RES_TIMEOUT = 64,
   parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       start,
   input  logic [1:0]                 mode,
   input  logic [15:0]                trans_num,
   complex_nr_mult_stim_gen_if.master mul,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [15:0]                trans_cnt
);

   // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned TMO_W     = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RES_TIMEOUT - 1);
   localparam logic             HAS_GAP  = (GAP_CYCLES != 0);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_GAP      = 3'd2,
      ST_SEND     = 3'd3,
      ST_WAIT_RES = 3'd4
   } state_t;

   state_t                state_q,     state_d;
   logic [1:0]            load_idx_q,  load_idx_d;
   logic [GAP_W-1:0]      gap_cnt_q,   gap_cnt_d;
   logic [TMO_W-1:0]      tmo_cnt_q,   tmo_cnt_d;
   logic [31:0]           lfsr_q,      lfsr_d;
   logic [1:0]            mode_q,      mode_d;
   logic [15:0]           trans_num_q, trans_num_d;
   logic [15:0]           trans_cnt_q, trans_cnt_d;
   logic [DATA_WIDTH-1:0] op_1_re_q,   op_1_re_d;
   logic [DATA_WIDTH-1:0] op_1_im_q,   op_1_im_d;
   logic [DATA_WIDTH-1:0] op_2_re_q,   op_2_re_d;
   logic [DATA_WIDTH-1:0] op_2_im_q,   op_2_im_d;
   logic                  done_q,      done_d;
   logic                  sw_rst_q,    sw_rst_d;
   logic                  err_q,       err_d;
`ifdef COMPLEX_STIM_RES_THROTTLE_EN
   logic                  rr_phase_q,  rr_phase_d;
`endif

   logic [31:0]           lfsr_next;
   logic [DATA_WIDTH-1:0] load_val;
   logic                  res_ready_int;
   logic                  last_trans;

   // Value of the operand written in the current LOAD cycle. The LFSR value
   // used is the post-advance one, so the first random operand after reset
   // is the seed stepped once. The transaction index k is trans_cnt_q.
   always_comb begin
      lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
      load_val  = '0;
      unique case (mode_q)
         2'd0: begin
            unique case (load_idx_q)
               2'd0:    load_val = DATA_WIDTH'(32'd2);
               2'd1:    load_val = DATA_WIDTH'(32'd3);
               2'd2:    load_val = DATA_WIDTH'(32'd4);
               default: load_val = DATA_WIDTH'(32'd2);
            endcase
         end
         2'd1:    load_val = lfsr_next[DATA_WIDTH-1:0];
         2'd2:    load_val = trans_cnt_q[0] ? DATA_WIDTH'(32'd1) : '1;
         default: load_val = DATA_WIDTH'(trans_cnt_q) + DATA_WIDTH'(load_idx_q);
      endcase
   end

`ifdef COMPLEX_STIM_RES_THROTTLE_EN
   assign res_ready_int = (state_q == ST_WAIT_RES) && rr_phase_q;
`else
   assign res_ready_int = (state_q == ST_WAIT_RES);
`endif

   // 17-bit compare so trans_num = 16'hFFFF completes without overflow
   assign last_trans = (({1'b0, trans_cnt_q} + 17'd1) == {1'b0, trans_num_q});

   always_comb begin
      state_d     = state_q;
      load_idx_d  = load_idx_q;
      gap_cnt_d   = gap_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      lfsr_d      = lfsr_q;
      mode_d      = mode_q;
      trans_num_d = trans_num_q;
      trans_cnt_d = trans_cnt_q;
      op_1_re_d   = op_1_re_q;
      op_1_im_d   = op_1_im_q;
      op_2_re_d   = op_2_re_q;
      op_2_im_d   = op_2_im_q;
      done_d      = 1'b0;
      sw_rst_d    = 1'b0;
      err_d       = err_q;
`ifdef COMPLEX_STIM_RES_THROTTLE_EN
      rr_phase_d  = rr_phase_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (trans_num != 16'd0) begin
                  state_d     = ST_LOAD;
                  mode_d      = mode;
                  trans_num_d = trans_num;
                  trans_cnt_d = 16'd0;
                  err_d       = 1'b0;
                  load_idx_d  = 2'd0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         ST_LOAD: begin
            // The LFSR only moves when it is actually supplying an operand
            if (mode_q == 2'd1) begin
               lfsr_d = lfsr_next;
            end
            unique case (load_idx_q)
               2'd0:    op_1_re_d = load_val;
               2'd1:    op_1_im_d = load_val;
               2'd2:    op_2_re_d = load_val;
               default: op_2_im_d = load_val;
            endcase
            load_idx_d = load_idx_q + 2'd1;
            if (load_idx_q == 2'd3) begin
               if (HAS_GAP) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else begin
                  state_d   = ST_SEND;
                  tmo_cnt_d = '0;
               end
            end
         end

         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = ST_SEND;
               tmo_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         ST_SEND: begin
            // op_val is high for the whole state, so op_ready alone completes it
            if (mul.op_ready) begin
               state_d   = ST_WAIT_RES;
               tmo_cnt_d = '0;
`ifdef COMPLEX_STIM_RES_THROTTLE_EN
               rr_phase_d = 1'b0;
`endif
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d  = ST_IDLE;
               err_d    = 1'b1;
               sw_rst_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         ST_WAIT_RES: begin
`ifdef COMPLEX_STIM_RES_THROTTLE_EN
            rr_phase_d = ~rr_phase_q;
`endif
            if (mul.res_val && res_ready_int) begin
               trans_cnt_d = (trans_cnt_q == 16'hFFFF) ? 16'hFFFF : trans_cnt_q + 16'd1;
               if (last_trans) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = ST_LOAD;
                  load_idx_d = 2'd0;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d  = ST_IDLE;
               err_d    = 1'b1;
               sw_rst_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         load_idx_q  <= 2'd0;
         gap_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         lfsr_q      <= LFSR_SEED;
         mode_q      <= 2'd0;
         trans_num_q <= 16'd0;
         trans_cnt_q <= 16'd0;
         op_1_re_q   <= '0;
         op_1_im_q   <= '0;
         op_2_re_q   <= '0;
         op_2_im_q   <= '0;
         done_q      <= 1'b0;
         sw_rst_q    <= 1'b0;
         err_q       <= 1'b0;
`ifdef COMPLEX_STIM_RES_THROTTLE_EN
         rr_phase_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         load_idx_q  <= load_idx_d;
         gap_cnt_q   <= gap_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         lfsr_q      <= lfsr_d;
         mode_q      <= mode_d;
         trans_num_q <= trans_num_d;
         trans_cnt_q <= trans_cnt_d;
         op_1_re_q   <= op_1_re_d;
         op_1_im_q   <= op_1_im_d;
         op_2_re_q   <= op_2_re_d;
         op_2_im_q   <= op_2_im_d;
         done_q      <= done_d;
         sw_rst_q    <= sw_rst_d;
         err_q       <= err_d;
`ifdef COMPLEX_STIM_RES_THROTTLE_EN
         rr_phase_q  <= rr_phase_d;
`endif
      end
   end

   assign mul.op_val    = (state_q == ST_SEND);
   assign mul.res_ready = res_ready_int;
   assign mul.sw_rst    = sw_rst_q;
   assign mul.op_1_re   = op_1_re_q;
   assign mul.op_1_im   = op_1_im_q;
   assign mul.op_2_re   = op_2_re_q;
   assign mul.op_2_im   = op_2_im_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign err           = err_q;
   assign trans_cnt     = trans_cnt_q;

endmodule
`default_nettype wire
